urv_mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM (1-cycle read latency) between the uRV instruction fetch port and the data load/store port. The block sits between the fetch stage, the execute-stage data interface and the on-chip memory. Data accesses take priority, and a starvation counter guarantees fetch progress. Fetch loses a cycle only when a data access is granted; `im_valid_o` low makes the fetch stage re-present the same address.

---
 rtl/urv_mem_arbiter_pkg.sv | 25 ++
 rtl/urv_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_urv_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_mem_arbiter_pkg.sv
// Shared types for the uRV fetch/data memory arbiter.
package urv_mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_LOAD  = 2'd2,
    GNT_STORE = 2'd3
  } grant_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [BE_W-1:0] sel;
  } dm_req_t;

  // Counter width able to hold the limit; never zero bits wide.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/urv_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and
// data load/store, data first, with a starvation guard for fetch.
module urv_mem_arbiter
  import urv_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AW       = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [XLEN-1:0]   im_addr_i,
  output logic [XLEN-1:0]   im_data_o,
  output logic              im_valid_o,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic [XLEN-1:0]   dm_data_s_i,
  input  logic [BE_W-1:0]   dm_data_select_i,
  input  logic              dm_store_i,
  input  logic              dm_load_i,
  output logic [XLEN-1:0]   dm_data_l_o,
  output logic              dm_load_done_o,
  output logic              dm_store_done_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_en_o,
  output logic [BE_W-1:0]   mem_we_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int unsigned      CNT_W    = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam bit               GUARD_EN = (STARVE_LIMIT != 0);

  grant_e          last_q;
  grant_e          grant_c;
  dm_req_t         st_q;
  dm_req_t         st_pulse_c;
  dm_req_t         st_cur_c;
  logic            st_vld_q;
  logic            ld_vld_q;
  logic [XLEN-1:0] ld_addr_q;
  logic [XLEN-1:0] ld_cur_c;
  logic [CNT_W-1:0] starve_q;
  logic            st_req_c;
  logic            ld_req_c;
  logic            force_fetch_c;

  // Request sources and priority: a held slot always beats a new pulse.
  always_comb begin
    st_pulse_c.addr = dm_addr_i;
    st_pulse_c.data = dm_data_s_i;
    st_pulse_c.sel  = dm_data_select_i;
    st_cur_c        = st_vld_q ? st_q : st_pulse_c;
    ld_cur_c        = ld_vld_q ? ld_addr_q : dm_addr_i;
    st_req_c        = st_vld_q | dm_store_i;
    ld_req_c        = ld_vld_q | dm_load_i;
    force_fetch_c   = GUARD_EN && (starve_q == CNT_MAX);
    grant_c         = GNT_FETCH;
    if (!force_fetch_c) begin
      if (st_req_c) begin
        grant_c = GNT_STORE;
      end else if (ld_req_c) begin
        grant_c = GNT_LOAD;
      end
    end
  end

  // RAM port steering; writes are held off while reset is asserted.
  always_comb begin
    mem_addr_o  = im_addr_i[MEM_AW+1:2];
    mem_we_o    = '0;
    mem_wdata_o = st_cur_c.data;
    case (grant_c)
      GNT_LOAD:  mem_addr_o = ld_cur_c[MEM_AW+1:2];
      GNT_STORE: begin
        mem_addr_o = st_cur_c.addr[MEM_AW+1:2];
        mem_we_o   = rst_n_i ? st_cur_c.sel : '0;
      end
      default: ;
    endcase
  end

  assign mem_en_o = rst_n_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q   <= GNT_NONE;
      st_vld_q <= 1'b0;
      ld_vld_q <= 1'b0;
      starve_q <= '0;
    end else begin
      last_q <= grant_c;

      // A pulse colliding with an occupied slot is dropped.
      if (st_vld_q) begin
        if (grant_c == GNT_STORE) st_vld_q <= 1'b0;
      end else if (dm_store_i && (grant_c != GNT_STORE)) begin
        st_vld_q <= 1'b1;
        st_q     <= st_pulse_c;
      end

      if (ld_vld_q) begin
        if (grant_c == GNT_LOAD) ld_vld_q <= 1'b0;
      end else if (dm_load_i && (grant_c != GNT_LOAD)) begin
        ld_vld_q  <= 1'b1;
        ld_addr_q <= dm_addr_i;
      end

      if (grant_c == GNT_FETCH) begin
        starve_q <= '0;
      end else if (starve_q != CNT_MAX) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

  assign im_valid_o      = (last_q == GNT_FETCH);
  assign dm_load_done_o  = (last_q == GNT_LOAD);
  assign dm_store_done_o = (last_q == GNT_STORE);
  assign im_data_o       = mem_rdata_i;
  assign dm_data_l_o     = mem_rdata_i;

  // Address bits outside the RAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr_i[XLEN-1:MEM_AW+2], im_addr_i[1:0],
                              ld_cur_c[XLEN-1:MEM_AW+2], ld_cur_c[1:0],
                              st_cur_c.addr[XLEN-1:MEM_AW+2], st_cur_c.addr[1:0]};

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Self-checking bench for urv_mem_arbiter: directed scenarios plus random
// traffic against a queue-based reference model and a shadow memory.
module tb_urv_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned LIMIT = 2;
  localparam int unsigned WORDS = 1 << AW;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } sreq_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   im_addr, dm_addr, dm_data_s;
  logic [3:0]    dm_sel;
  logic          dm_store, dm_load;
  logic [31:0]   im_data_o, dm_data_l_o, mem_wdata_o, mem_rdata;
  logic          im_valid_o, dm_load_done_o, dm_store_done_o, mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_we_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  urv_mem_arbiter #(.MEM_AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .im_addr_i(im_addr), .im_data_o(im_data_o), .im_valid_o(im_valid_o),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_store_i(dm_store), .dm_load_i(dm_load),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
    .dm_store_done_o(dm_store_done_o),
    .mem_addr_o(mem_addr_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    if (a == AW'('h40)) return 32'hDEADBEEF;
    if (a == AW'('h80)) return 32'hAAAAAAAA;
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous RAM, read-before-write, contents start at init_val.
  logic [31:0] ram     [0:WORDS-1];
  bit          written [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata <= written[mem_addr_o] ? ram[mem_addr_o] : init_val(mem_addr_o);
      if (mem_we_o != 4'b0) begin
        ram[mem_addr_o]     <= merge(written[mem_addr_o] ? ram[mem_addr_o]
                                     : init_val(mem_addr_o), mem_wdata_o, mem_we_o);
        written[mem_addr_o] <= 1'b1;
      end
    end
  end

  // Reference model: pending requests as queues, plain integer counter.
  sreq_t       st_pend[$];
  logic [31:0] ld_pend[$];
  logic [31:0] shadow [0:WORDS-1];
  int          starve;
  int          exp_kind;   // 0 none, 1 fetch, 2 load, 3 store
  logic [31:0] exp_word;

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  function automatic int pick();
    bit want_st, want_ld;
    want_st = (st_pend.size() > 0) || dm_store;
    want_ld = (ld_pend.size() > 0) || dm_load;
    if ((LIMIT > 0) && (starve >= int'(LIMIT))) return 1;
    if (want_st) return 3;
    if (want_ld) return 2;
    return 1;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int g);
    if (g == 3) return word_of(st_pend.size() > 0 ? st_pend[0].addr : dm_addr);
    if (g == 2) return word_of(ld_pend.size() > 0 ? ld_pend[0] : dm_addr);
    return word_of(im_addr);
  endfunction

  function automatic logic [3:0] exp_we(input int g);
    if (g != 3) return 4'b0;
    return st_pend.size() > 0 ? st_pend[0].sel : dm_sel;
  endfunction

  function automatic logic [31:0] exp_wdata();
    return st_pend.size() > 0 ? st_pend[0].data : dm_data_s;
  endfunction

  function automatic void model_update();
    int    g;
    sreq_t s;
    logic [31:0] a;
    if (!rst_n) begin
      st_pend.delete();
      ld_pend.delete();
      starve   = 0;
      exp_kind = 0;
      return;
    end
    g = pick();
    if (dm_store && st_pend.size() == 0) begin
      s.addr = dm_addr; s.data = dm_data_s; s.sel = dm_sel;
      st_pend.push_back(s);
    end
    if (dm_load && ld_pend.size() == 0) ld_pend.push_back(dm_addr);
    if (g == 3) begin
      s = st_pend.pop_front();
      shadow[word_of(s.addr)] = merge(shadow[word_of(s.addr)], s.data, s.sel);
    end else if (g == 2) begin
      a = ld_pend.pop_front();
      exp_word = shadow[word_of(a)];
    end else begin
      exp_word = shadow[word_of(im_addr)];
    end
    starve   = (g == 1) ? 0 : ((starve + 1 > int'(LIMIT)) ? int'(LIMIT) : starve + 1);
    exp_kind = g;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    dm_store = 1'b0;
    dm_load  = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_pulses();
    for (int i = 0; i < n; i++) begin
      im_addr = $urandom;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; im_addr = 32'h0; clear_pulses();
    dm_addr = 32'h0; dm_data_s = 32'h0; dm_sel = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if ({im_valid_o, dm_load_done_o, dm_store_done_o} !== 3'b000) begin
        failures++;
        $display("FAIL reset_resp: got %b expected 000", {im_valid_o, dm_load_done_o, dm_store_done_o});
      end
      if (mem_en_o !== 1'b0) begin
        failures++; $display("FAIL reset_en: got %b expected 0", mem_en_o);
      end
    end
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (mem_en_o !== 1'b1) begin
      failures++; $display("FAIL release_en: got %b expected 1", mem_en_o);
    end
    if (mem_addr_o !== AW'(0) || mem_we_o !== 4'b0) begin
      failures++; $display("FAIL release_addr: got %h/%b expected 0/0000", mem_addr_o, mem_we_o);
    end
    tick();
    checks += 2;
    if (im_valid_o !== 1'b1) begin
      failures++; $display("FAIL first_fetch_valid: got %b expected 1", im_valid_o);
    end
    if (im_data_o !== init_val(AW'(0))) begin
      failures++; $display("FAIL first_fetch_data: got %h expected %h", im_data_o, init_val(AW'(0)));
    end
  endtask

  task automatic test_load();
    idle(2);
    im_addr = $urandom; dm_addr = 32'h100; dm_load = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== AW'('h40) || mem_we_o !== 4'b0) begin
      failures++; $display("FAIL load_port: got %h/%b expected 040/0000", mem_addr_o, mem_we_o);
    end
    tick();
    clear_pulses();
    checks += 2;
    if ({dm_load_done_o, im_valid_o, dm_store_done_o} !== 3'b100) begin
      failures++; $display("FAIL load_done: got %b expected 100", {dm_load_done_o, im_valid_o, dm_store_done_o});
    end
    if (dm_data_l_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_data: got %h expected deadbeef", dm_data_l_o);
    end
  endtask

  task automatic test_store_be();
    idle(2);
    dm_addr = 32'h200; dm_data_s = 32'h11223344; dm_sel = 4'b0011; dm_store = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== AW'('h80) || mem_we_o !== 4'b0011 || mem_wdata_o !== 32'h11223344) begin
      failures++;
      $display("FAIL store_port: got %h/%b/%h expected 080/0011/11223344", mem_addr_o, mem_we_o, mem_wdata_o);
    end
    tick();
    clear_pulses();
    checks++;
    if ({dm_store_done_o, im_valid_o} !== 2'b10) begin
      failures++; $display("FAIL store_done: got %b expected 10", {dm_store_done_o, im_valid_o});
    end
    idle(2);
    dm_addr = 32'h200; dm_load = 1'b1;
    tick();
    clear_pulses();
    checks++;
    if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'hAAAA3344) begin
      failures++; $display("FAIL store_readback: got %b/%h expected 1/aaaa3344", dm_load_done_o, dm_data_l_o);
    end
  endtask

  task automatic test_simultaneous();
    idle(2);
    dm_addr = 32'h10; dm_data_s = $urandom; dm_sel = 4'hF;
    dm_store = 1'b1; dm_load = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== AW'(4) || mem_we_o !== 4'hF) begin
      failures++; $display("FAIL simul_store_port: got %h/%b expected 004/1111", mem_addr_o, mem_we_o);
    end
    tick();
    clear_pulses();
    dm_addr = 32'h0;  // ignored: load must come from its slot
    checks++;
    if ({dm_store_done_o, dm_load_done_o, im_valid_o} !== 3'b100) begin
      failures++; $display("FAIL simul_n1: got %b expected 100", {dm_store_done_o, dm_load_done_o, im_valid_o});
    end
    #1;
    checks++;
    if (mem_addr_o !== AW'(4) || mem_we_o !== 4'b0) begin
      failures++; $display("FAIL simul_load_port: got %h/%b expected 004/0000", mem_addr_o, mem_we_o);
    end
    tick();
    checks += 2;
    if ({dm_store_done_o, dm_load_done_o, im_valid_o} !== 3'b010) begin
      failures++; $display("FAIL simul_n2: got %b expected 010", {dm_store_done_o, dm_load_done_o, im_valid_o});
    end
    if (dm_data_l_o !== exp_word) begin
      failures++; $display("FAIL simul_load_data: got %h expected %h", dm_data_l_o, exp_word);
    end
    tick();
    checks++;
    if (im_valid_o !== 1'b1) begin
      failures++; $display("FAIL simul_fetch_resume: got %b expected 1", im_valid_o);
    end
  endtask

  task automatic test_random();
    int g, gap, max_gap;
    gap = 0; max_gap = 0;
    for (int i = 0; i < 400; i++) begin
      im_addr   = $urandom;
      dm_addr   = $urandom;
      dm_data_s = $urandom;
      dm_sel    = 4'($urandom);
      dm_store  = ($urandom_range(3) == 0);
      dm_load   = ($urandom_range(2) == 0);
      #1;
      g = pick();
      checks++;
      if (mem_addr_o !== exp_addr(g) || mem_we_o !== exp_we(g) ||
          (g == 3 && mem_wdata_o !== exp_wdata())) begin
        failures++;
        $display("FAIL rand_port cyc%0d: got %h/%b/%h expected %h/%b/%h", i,
                 mem_addr_o, mem_we_o, mem_wdata_o, exp_addr(g), exp_we(g), exp_wdata());
      end
      tick();
      checks++;
      if ({im_valid_o, dm_load_done_o, dm_store_done_o} !==
          {exp_kind == 1, exp_kind == 2, exp_kind == 3}) begin
        failures++;
        $display("FAIL rand_resp cyc%0d: got %b expected kind %0d", i,
                 {im_valid_o, dm_load_done_o, dm_store_done_o}, exp_kind);
      end
      if (exp_kind == 1 || exp_kind == 2) begin
        checks++;
        if ((exp_kind == 1 ? im_data_o : dm_data_l_o) !== exp_word) begin
          failures++;
          $display("FAIL rand_data cyc%0d: got %h expected %h", i,
                   exp_kind == 1 ? im_data_o : dm_data_l_o, exp_word);
        end
      end
      gap = im_valid_o ? 0 : gap + 1;
      if (gap > max_gap) max_gap = gap;
    end
    clear_pulses();
    checks++;
    if (max_gap > int'(LIMIT)) begin
      failures++; $display("FAIL rand_fetch_gap: got %0d expected <= %0d", max_gap, LIMIT);
    end
  endtask

  task automatic test_starvation();
    int  gap, max_gap, done_cnt, cyc;
    bit  issue, kind;
    idle(2);
    gap = 0; max_gap = 0; done_cnt = 0; cyc = 0; issue = 1'b1; kind = 1'b0;
    while (done_cnt < 20 && cyc < 100) begin
      im_addr = $urandom;
      if (issue) begin
        dm_addr = $urandom; dm_data_s = $urandom; dm_sel = 4'($urandom);
        dm_load = ~kind; dm_store = kind;
        kind = ~kind; issue = 1'b0;
      end
      tick();
      clear_pulses();
      cyc++;
      checks++;
      if ({im_valid_o, dm_load_done_o, dm_store_done_o} !==
          {exp_kind == 1, exp_kind == 2, exp_kind == 3}) begin
        failures++;
        $display("FAIL starve_resp cyc%0d: got %b expected kind %0d", cyc,
                 {im_valid_o, dm_load_done_o, dm_store_done_o}, exp_kind);
      end
      if (dm_load_done_o || dm_store_done_o) begin
        done_cnt++; issue = 1'b1;
      end
      gap = im_valid_o ? 0 : gap + 1;
      if (gap > max_gap) max_gap = gap;
    end
    checks += 2;
    if (done_cnt != 20) begin
      failures++; $display("FAIL starve_progress: got %0d completions expected 20 within 100 cycles", done_cnt);
    end
    if (max_gap > int'(LIMIT)) begin
      failures++; $display("FAIL starve_gap: got %0d expected <= %0d", max_gap, LIMIT);
    end
  endtask

  task automatic test_reset_during_load();
    idle(2);
    dm_addr = $urandom; dm_load = 1'b1; rst_n = 1'b0;
    tick();
    clear_pulses();
    checks++;
    if ({dm_load_done_o, im_valid_o, mem_en_o} !== 3'b000) begin
      failures++; $display("FAIL rst_load_n1: got %b expected 000", {dm_load_done_o, im_valid_o, mem_en_o});
    end
    tick();
    rst_n = 1'b1;
    checks++;
    if (dm_load_done_o !== 1'b0) begin
      failures++; $display("FAIL rst_load_n2: got %b expected 0", dm_load_done_o);
    end
    tick();
    checks++;
    if ({im_valid_o, dm_load_done_o} !== 2'b10) begin
      failures++; $display("FAIL rst_load_after: got %b expected 10", {im_valid_o, dm_load_done_o});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(WORDS); i++) shadow[i] = init_val(AW'(i));
    starve = 0; exp_kind = 0; exp_word = 32'h0;
    test_reset();
    test_load();
    test_store_be();
    test_simultaneous();
    test_random();
    test_starvation();
    test_reset_during_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
